// File: rtl/mario_vram_arbiter_pkg.sv
// Shared types and constants for the background tile VRAM arbiter.
package mario_vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        HOLD    = 2'd2
    } arb_state_e;

    localparam logic [1:0] WIN_PHASE   = 2'b11;
    localparam logic [2:0] GUARD_PHASE = 3'b101;

    localparam int ACC_CYCLES_MIN = 1;
    localparam int ACC_CYCLES_MAX = 8;
    localparam int FETCH_LAT_MIN  = 1;
    localparam int FETCH_LAT_MAX  = 3;

    // Keeps an out-of-range parameter from producing a zero-length or overflowing counter.
    function automatic int clamp_param(input int val, input int lo, input int hi);
        if (val < lo) begin
            return lo;
        end else if (val > hi) begin
            return hi;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/mario_vram_arbiter_if.sv
// CPU-side VRAM bus: address/data/strobes from the CPU decode, read data and wait back.
interface mario_vram_arbiter_if;
    logic [9:0] I_CPU_AB;
    logic [7:0] I_CPU_DB;
    logic       I_CPU_CSn;
    logic       I_CPU_RDn;
    logic       I_CPU_WRn;
    logic [7:0] O_CPU_DB;
    logic       O_WAITn;

    modport master (
        output I_CPU_AB, I_CPU_DB, I_CPU_CSn, I_CPU_RDn, I_CPU_WRn,
        input  O_CPU_DB, O_WAITn
    );

    modport slave (
        input  I_CPU_AB, I_CPU_DB, I_CPU_CSn, I_CPU_RDn, I_CPU_WRn,
        output O_CPU_DB, O_WAITn
    );
endinterface

// File: rtl/mario_vram_slot_gen.sv
// Decodes the video fetch window and its guard band from the horizontal phase.
module mario_vram_slot_gen
    import mario_vram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] h_phase,
    input  logic       cmpblk,
    output logic       win_s,
    output logic       guard_s,
    output logic       win_rise_s,
    output logic       vrambusy_n_s
);
    logic win_d;
    logic win_q;

    assign win_s        = cmpblk & (h_phase[3:2] == WIN_PHASE);
    assign guard_s      = cmpblk & (h_phase[3:1] == GUARD_PHASE);
    assign win_rise_s   = win_s & ~win_q;
    assign vrambusy_n_s = ~(win_s | guard_s);

    // Previous-window value for the rising-edge detect.
    always_comb begin
        win_d = win_s;
    end

    // Resetting to 1 suppresses a spurious fetch if reset releases inside a window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= 1'b1;
        end else begin
            win_q <= win_d;
        end
    end
endmodule

// File: rtl/mario_vram_arbiter.sv
// Background tile VRAM arbiter: CPU access FSM, once-per-window tile fetch and RAM muxing.
// Build option MARIO_VRAM_CPU_ACTIVE_EN also grants CPU accesses during active display.
module mario_vram_arbiter
    import mario_vram_arb_pkg::*;
#(
    parameter int ACC_CYCLES = 3,
    parameter int FETCH_LAT  = 2
) (
    input  logic                 I_CLK_24M,
    input  logic                 I_RST,
    input  logic [9:0]           I_H_CNT,
    input  logic                 I_CMPBLK,
    input  logic [9:0]           I_VID_AB,
    mario_vram_arbiter_if.slave  cpu,
    input  logic [7:0]           I_RAM_Q,
    output logic [9:0]           O_RAM_AB,
    output logic [7:0]           O_RAM_D,
    output logic                 O_RAM_CE,
    output logic                 O_RAM_WE,
    output logic [7:0]           O_TILE,
    output logic                 O_TILE_VLD,
    output logic                 O_FETCH_LATE,
    output logic                 O_VRAMBUSYn
);
    localparam int         ACC_N    = clamp_param(ACC_CYCLES, ACC_CYCLES_MIN, ACC_CYCLES_MAX);
    localparam int         LAT_N    = clamp_param(FETCH_LAT, FETCH_LAT_MIN, FETCH_LAT_MAX);
    localparam logic [2:0] ACC_LAST = 3'(ACC_N - 1);
    localparam logic [1:0] LAT_LAST = 2'(LAT_N - 1);

    arb_state_e state_q, state_d;
    logic [2:0] acc_cnt_q, acc_cnt_d;
    logic       is_wr_q, is_wr_d;
    logic [9:0] acc_ab_q, acc_ab_d;
    logic [7:0] acc_wd_q, acc_wd_d;
    logic [7:0] cpu_db_q, cpu_db_d;
    logic       pend_q, pend_d;
    logic       fbusy_q, fbusy_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic       flate_q, flate_d;
    logic [7:0] tile_q, tile_d;
    logic       tile_vld_q, tile_vld_d;
    logic       fetch_late_q, fetch_late_d;

    logic       win_s, guard_s, win_rise_s;
    logic       cpu_req_s, cpu_allowed_s, grant_s;
    logic       fetch_start_s, fetch_active_s, fetch_late_s;
    logic [1:0] fcount_s;
    logic       unused_h_cnt_s;

    assign unused_h_cnt_s = ^I_H_CNT[9:4];

    mario_vram_slot_gen u_slot_gen (
        .clk          (I_CLK_24M),
        .rst          (I_RST),
        .h_phase      (I_H_CNT[3:0]),
        .cmpblk       (I_CMPBLK),
        .win_s        (win_s),
        .guard_s      (guard_s),
        .win_rise_s   (win_rise_s),
        .vrambusy_n_s (O_VRAMBUSYn)
    );

`ifdef MARIO_VRAM_CPU_ACTIVE_EN
    assign cpu_allowed_s = 1'b1;
`else
    assign cpu_allowed_s = ~I_CMPBLK;
`endif

    assign cpu_req_s = ~cpu.I_CPU_CSn & (~cpu.I_CPU_RDn | ~cpu.I_CPU_WRn);

    // A window opening during CPU_ACC is parked in pend_q and started once the RAM is free.
    assign fetch_start_s  = (win_rise_s | pend_q) & (state_q != CPU_ACC);
    assign fetch_active_s = fetch_start_s | fbusy_q;
    assign fcount_s       = fetch_start_s ? 2'd0 : fcnt_q;
    assign fetch_late_s   = fetch_start_s ? pend_q : flate_q;

    assign grant_s = (state_q == IDLE) & cpu_req_s & ~win_s & ~guard_s & cpu_allowed_s
                   & ~fetch_active_s & ~pend_q;

    assign cpu.O_WAITn  = ~(cpu_req_s & ~I_RST & ((state_q == IDLE) | (state_q == CPU_ACC)));
    assign cpu.O_CPU_DB = cpu_db_q;
    assign O_TILE       = tile_q;
    assign O_TILE_VLD   = tile_vld_q;
    assign O_FETCH_LATE = fetch_late_q;

    // RAM port mux: video fetch has priority, CPU only during CPU_ACC, otherwise idle.
    always_comb begin
        O_RAM_AB = 10'h000;
        O_RAM_D  = 8'h00;
        O_RAM_CE = 1'b0;
        O_RAM_WE = 1'b0;
        if (fetch_active_s) begin
            O_RAM_AB = I_VID_AB;
            O_RAM_CE = 1'b1;
        end else if (state_q == CPU_ACC) begin
            O_RAM_AB = acc_ab_q;
            O_RAM_D  = acc_wd_q;
            O_RAM_CE = 1'b1;
            O_RAM_WE = is_wr_q;
        end else begin
            O_RAM_CE = 1'b0;
        end
    end

    // Next-state for the CPU access FSM and the tile fetch sequencer.
    always_comb begin
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q;
        is_wr_d      = is_wr_q;
        acc_ab_d     = acc_ab_q;
        acc_wd_d     = acc_wd_q;
        cpu_db_d     = cpu_db_q;
        pend_d       = pend_q;
        fbusy_d      = fbusy_q;
        fcnt_d       = fcnt_q;
        flate_d      = flate_q;
        tile_d       = tile_q;
        tile_vld_d   = 1'b0;
        fetch_late_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d   = CPU_ACC;
                    acc_cnt_d = 3'd0;
                    is_wr_d   = ~cpu.I_CPU_WRn;
                    acc_ab_d  = cpu.I_CPU_AB;
                    acc_wd_d  = cpu.I_CPU_DB;
                end else begin
                    state_d = IDLE;
                end
            end
            CPU_ACC: begin
                if (acc_cnt_q == ACC_LAST) begin
                    state_d  = HOLD;
                    cpu_db_d = is_wr_q ? 8'h00 : I_RAM_Q;
                end else begin
                    acc_cnt_d = acc_cnt_q + 3'd1;
                end
            end
            HOLD: begin
                // Waiting for the strobe to drop keeps one bus cycle from writing twice.
                if (!cpu_req_s) begin
                    state_d  = IDLE;
                    cpu_db_d = 8'h00;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (win_rise_s && (state_q == CPU_ACC)) begin
            pend_d = 1'b1;
        end else if (fetch_start_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        if (fetch_active_s) begin
            if (fcount_s == LAT_LAST) begin
                fbusy_d      = 1'b0;
                fcnt_d       = 2'd0;
                flate_d      = 1'b0;
                tile_d       = I_RAM_Q;
                tile_vld_d   = 1'b1;
                fetch_late_d = fetch_late_s;
            end else begin
                fbusy_d = 1'b1;
                fcnt_d  = fcount_s + 2'd1;
                flate_d = fetch_late_s;
            end
        end else begin
            fbusy_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge I_CLK_24M or posedge I_RST) begin
        if (I_RST) begin
            state_q      <= IDLE;
            acc_cnt_q    <= 3'd0;
            is_wr_q      <= 1'b0;
            acc_ab_q     <= 10'h000;
            acc_wd_q     <= 8'h00;
            cpu_db_q     <= 8'h00;
            pend_q       <= 1'b0;
            fbusy_q      <= 1'b0;
            fcnt_q       <= 2'd0;
            flate_q      <= 1'b0;
            tile_q       <= 8'h00;
            tile_vld_q   <= 1'b0;
            fetch_late_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            is_wr_q      <= is_wr_d;
            acc_ab_q     <= acc_ab_d;
            acc_wd_q     <= acc_wd_d;
            cpu_db_q     <= cpu_db_d;
            pend_q       <= pend_d;
            fbusy_q      <= fbusy_d;
            fcnt_q       <= fcnt_d;
            flate_q      <= flate_d;
            tile_q       <= tile_d;
            tile_vld_q   <= tile_vld_d;
            fetch_late_q <= fetch_late_d;
        end
    end
endmodule

// File: tb/tb_mario_vram_arbiter.sv
// Directed bench for mario_vram_arbiter with a behavioural 1KB RAM on the RAM port.
module tb_mario_vram_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] h_cnt;
    logic       cmpblk;
    logic [9:0] vid_ab;
    logic [7:0] ram_q;
    logic [9:0] ram_ab;
    logic [7:0] ram_d;
    logic       ram_ce, ram_we;
    logic [7:0] tile;
    logic       tile_vld, fetch_late, busy_n;

    logic [7:0] mem [0:1023];
    int         wr_cnt = 0;
    int         wc0;
    int         total  = 0;
    int         passed = 0;

    mario_vram_arbiter_if cif ();

    mario_vram_arbiter dut (
        .I_CLK_24M    (clk),
        .I_RST        (rst),
        .I_H_CNT      (h_cnt),
        .I_CMPBLK     (cmpblk),
        .I_VID_AB     (vid_ab),
        .cpu          (cif),
        .I_RAM_Q      (ram_q),
        .O_RAM_AB     (ram_ab),
        .O_RAM_D      (ram_d),
        .O_RAM_CE     (ram_ce),
        .O_RAM_WE     (ram_we),
        .O_TILE       (tile),
        .O_TILE_VLD   (tile_vld),
        .O_FETCH_LATE (fetch_late),
        .O_VRAMBUSYn  (busy_n)
    );

    always #5 clk = ~clk;

    assign ram_q = mem[ram_ab];

    // RAM model: a write lands mid-cycle while CE and WE are both high.
    always @(negedge clk) begin
        if (ram_ce && ram_we) begin
            mem[ram_ab] = ram_d;
            wr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; h_cnt = 10'h000; cmpblk = 1'b0; vid_ab = 10'h000;
        cif.I_CPU_AB = 10'h000; cif.I_CPU_DB = 8'h00;
        cif.I_CPU_CSn = 1'b1; cif.I_CPU_RDn = 1'b1; cif.I_CPU_WRn = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        step(); step(); #1;
        chk("rst_waitn", cif.O_WAITn, 1'b1);
        chk("rst_busyn", busy_n, 1'b1);
        chk("rst_ce", ram_ce, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_cpu_db", cif.O_CPU_DB, 8'h00);
        chk("rst_tile", tile, 8'h00);
        chk("rst_vld", tile_vld, 1'b0);
        chk("rst_late", fetch_late, 1'b0);
        rst = 1'b0;

        // CPU write A5 -> 123 with display blanked
        step();
        cif.I_CPU_AB = 10'h123; cif.I_CPU_DB = 8'hA5; cif.I_CPU_CSn = 1'b0; cif.I_CPU_WRn = 1'b0;
        #1;
        chk("wr_req_waitn", cif.O_WAITn, 1'b0);
        chk("wr_req_ce", ram_ce, 1'b0);
        wc0 = wr_cnt;
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("wr_acc_we", ram_we, 1'b1);
            chk("wr_acc_ab", ram_ab, 10'h123);
            chk("wr_acc_d", ram_d, 8'hA5);
            chk("wr_acc_waitn", cif.O_WAITn, 1'b0);
        end
        step(); #1;
        chk("wr_hold_waitn", cif.O_WAITn, 1'b1);
        chk("wr_hold_ce", ram_ce, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("wr_hold_no_we", ram_we, 1'b0);
        end
        cif.I_CPU_CSn = 1'b1; cif.I_CPU_WRn = 1'b1;
        step(); #1;
        chk("wr_we_cycles", wr_cnt - wc0, 3);
        chk("wr_mem", mem[10'h123], 8'hA5);

        // CPU read of 3C from 123
        mem[10'h123] = 8'h3C;
        step();
        cif.I_CPU_AB = 10'h123; cif.I_CPU_CSn = 1'b0; cif.I_CPU_RDn = 1'b0;
        #1;
        chk("rd_req_waitn", cif.O_WAITn, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("rd_acc_ce", ram_ce, 1'b1);
            chk("rd_acc_we", ram_we, 1'b0);
            chk("rd_acc_db", cif.O_CPU_DB, 8'h00);
        end
        step(); #1;
        chk("rd_hold_db", cif.O_CPU_DB, 8'h3C);
        chk("rd_hold_waitn", cif.O_WAITn, 1'b1);
        step(); #1;
        chk("rd_hold_db2", cif.O_CPU_DB, 8'h3C);
        cif.I_CPU_CSn = 1'b1; cif.I_CPU_RDn = 1'b1;
        step(); #1;
        chk("rd_release_db", cif.O_CPU_DB, 8'h00);

        // Video tile fetch at window start
        mem[10'h2F0] = 8'h47; vid_ab = 10'h2F0; cmpblk = 1'b1; h_cnt = 10'h008;
        step(); #1;
        chk("vid_pre_busyn", busy_n, 1'b1);
        chk("vid_pre_ce", ram_ce, 1'b0);
        step(); h_cnt = 10'h00C; #1;
        chk("vid_ab", ram_ab, 10'h2F0);
        chk("vid_ce", ram_ce, 1'b1);
        chk("vid_busyn", busy_n, 1'b0);
        chk("vid_vld0", tile_vld, 1'b0);
        step(); #1;
        chk("vid_ab1", ram_ab, 10'h2F0);
        chk("vid_vld1", tile_vld, 1'b0);
        step(); #1;
        chk("vid_tile", tile, 8'h47);
        chk("vid_vld2", tile_vld, 1'b1);
        chk("vid_late", fetch_late, 1'b0);
        chk("vid_ce_done", ram_ce, 1'b0);
        step(); #1;
        chk("vid_vld_once", tile_vld, 1'b0);
        step(); h_cnt = 10'h00D; #1;
        chk("vid_one_fetch", ram_ce, 1'b0);

        // CPU request arriving in the guard band
        mem[10'h010] = 8'h00;
        step(); h_cnt = 10'h00A;
        cif.I_CPU_AB = 10'h010; cif.I_CPU_DB = 8'h5A; cif.I_CPU_CSn = 1'b0; cif.I_CPU_WRn = 1'b0;
        #1;
        chk("grd_busyn", busy_n, 1'b0);
        chk("grd_waitn", cif.O_WAITn, 1'b0);
        chk("grd_ce", ram_ce, 1'b0);
        step(); h_cnt = 10'h00B; #1;
        chk("grd_waitn_b", cif.O_WAITn, 1'b0);
        chk("grd_ce_b", ram_ce, 1'b0);
        step(); h_cnt = 10'h000; #1;
        chk("grd_waitn_0", cif.O_WAITn, 1'b0);
`ifdef MARIO_VRAM_CPU_ACTIVE_EN
        step(); #1;
        chk("grd_grant_we", ram_we, 1'b1);
        chk("grd_grant_ab", ram_ab, 10'h010);
`else
        step(); #1;
        chk("grd_blocked_ce", ram_ce, 1'b0);
        chk("grd_blocked_waitn", cif.O_WAITn, 1'b0);
        cmpblk = 1'b0; #1;
        step(); #1;
        chk("grd_grant_we", ram_we, 1'b1);
        chk("grd_grant_ab", ram_ab, 10'h010);
`endif
        step(); step(); step(); #1;
        chk("grd_hold_waitn", cif.O_WAITn, 1'b1);
        cif.I_CPU_CSn = 1'b1; cif.I_CPU_WRn = 1'b1; cmpblk = 1'b0;
        step(); #1;
        chk("grd_mem", mem[10'h010], 8'h5A);

        // Window opens during a CPU write: deferred fetch
        mem[10'h2F0] = 8'h9E; h_cnt = 10'h00C;
        step();
        cif.I_CPU_AB = 10'h200; cif.I_CPU_DB = 8'h77; cif.I_CPU_CSn = 1'b0; cif.I_CPU_WRn = 1'b0;
        #1;
        chk("late_req_waitn", cif.O_WAITn, 1'b0);
        step(); cmpblk = 1'b1; #1;
        chk("late_acc1_we", ram_we, 1'b1);
        chk("late_acc1_ab", ram_ab, 10'h200);
        chk("late_acc1_busyn", busy_n, 1'b0);
        step(); #1;
        chk("late_acc2_ab", ram_ab, 10'h200);
        step(); #1;
        chk("late_acc3_we", ram_we, 1'b1);
        step(); #1;
        chk("late_fetch_ab", ram_ab, 10'h2F0);
        chk("late_fetch_we", ram_we, 1'b0);
        chk("late_fetch_waitn", cif.O_WAITn, 1'b1);
        step(); #1;
        chk("late_fetch_ce", ram_ce, 1'b1);
        step(); #1;
        chk("late_tile", tile, 8'h9E);
        chk("late_vld", tile_vld, 1'b1);
        chk("late_flag", fetch_late, 1'b1);
        step(); #1;
        chk("late_flag_off", fetch_late, 1'b0);
        chk("late_mem", mem[10'h200], 8'h77);
        cif.I_CPU_CSn = 1'b1; cif.I_CPU_WRn = 1'b1; cmpblk = 1'b0; h_cnt = 10'h000;

        // Asynchronous reset in the first clock of a write access
        mem[10'h300] = 8'h11;
        step();
        cif.I_CPU_AB = 10'h300; cif.I_CPU_DB = 8'hEE; cif.I_CPU_CSn = 1'b0; cif.I_CPU_WRn = 1'b0;
        #1;
        step(); #1;
        chk("ar_acc_we", ram_we, 1'b1);
        wc0 = wr_cnt;
        rst = 1'b1; #1;
        chk("ar_we", ram_we, 1'b0);
        chk("ar_ce", ram_ce, 1'b0);
        chk("ar_waitn", cif.O_WAITn, 1'b1);
        chk("ar_tile", tile, 8'h00);
        chk("ar_cpu_db", cif.O_CPU_DB, 8'h00);
        step();
        cif.I_CPU_CSn = 1'b1; cif.I_CPU_WRn = 1'b1; rst = 1'b0;
        step(); #1;
        chk("ar_no_write", wr_cnt - wc0, 0);
        chk("ar_mem", mem[10'h300], 8'h11);
        chk("ar_idle_ce", ram_ce, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mario_vram_arbiter.md
Name: mario_vram_arbiter

Overview:
- Time-shares the 1KB background tile VRAM (2114 pair) between CPU read/write requests and the video tile-code fetch.
- Owns the RAM address, data, CE and WE muxing.
- Drives the CPU wait handshake and the VRAM-busy flag.
- Latches the fetched tile code for the tile ROM / shift-register path.
- Sits between the CPU bus decode and the VRAM plus tile-fetch datapath.

Parameters:
- ACC_CYCLES, 3: I_CLK_24M clocks a CPU access holds the RAM (1..8).
- FETCH_LAT, 2: clocks from presenting the video address to O_TILE being captured (1..3).

Ports:
- I_CLK_24M  in  1  sole clock, all state updates on posedge
- I_RST  in  1  asynchronous, active-high reset
- I_H_CNT  in  10  horizontal counter; advances once per 4 I_CLK_24M clocks
- I_CMPBLK  in  1  1 = active display (video fetch windows enabled)
- I_VID_AB  in  10  tile address {VF[7:3],HF[4:0]} from the counter datapath
- I_CPU_AB  in  10  CPU address
- I_CPU_DB  in  8  CPU write data
- I_CPU_CSn  in  1  VRAM chip select, active low
- I_CPU_RDn  in  1  read strobe, active low
- I_CPU_WRn  in  1  write strobe, active low
- I_RAM_Q  in  8  RAM read data
- O_RAM_AB  out  10  RAM address
- O_RAM_D  out  8  RAM write data
- O_RAM_CE  out  1  RAM enable, active high
- O_RAM_WE  out  1  RAM write enable, active high
- O_CPU_DB  out  8  read data to CPU; 8'h00 unless a completed read is held
- O_WAITn  out  1  CPU wait, active low
- O_TILE  out  8  latched tile code
- O_TILE_VLD  out  1  one-clock strobe when O_TILE updates
- O_FETCH_LATE  out  1  one-clock strobe when a fetch was deferred behind a CPU access
- O_VRAMBUSYn  out  1  low while the video owns, or is about to own, the RAM

Behaviour:
- Reset values: O_WAITn=1, O_VRAMBUSYn=1, O_RAM_CE=0, O_RAM_WE=0, O_CPU_DB=0, O_TILE=0, O_TILE_VLD=0, O_FETCH_LATE=0, state=IDLE. Reset mid-access aborts the access with no write committed.
- Signal definitions:
  - cpu_req = ~I_CPU_CSn & (~I_CPU_RDn | ~I_CPU_WRn).
  - win = I_CMPBLK & (I_H_CNT[3:2]==2'b11).
  - guard = I_CMPBLK & (I_H_CNT[3:1]==3'b101).
  - O_VRAMBUSYn = ~(win | guard).
- Video fetch:
  - On the first clock of win (rising edge, registered detect), O_RAM_AB=I_VID_AB and O_RAM_CE=1.
  - After FETCH_LAT clocks, O_TILE<=I_RAM_Q and O_TILE_VLD pulses.
  - Exactly one fetch per window.
- States:
  - IDLE -> CPU_ACC when cpu_req & ~win & ~guard & cpu_allowed & no fetch in flight.
  - CPU_ACC lasts ACC_CYCLES clocks:
    - O_RAM_AB=I_CPU_AB, CE=1.
    - WE=1 on every clock of CPU_ACC only if a write is in progress.
    - The read is captured on the last clock.
  - CPU_ACC -> HOLD: O_WAITn=1.
    - For a read, O_CPU_DB holds the captured data.
    - Stays in HOLD until cpu_req=0, then O_CPU_DB<=0 and the state returns to IDLE. This blocks double writes.
  - Outside fetch windows and CPU_ACC, O_RAM_CE=0 and O_RAM_WE=0.
- Wait handshake:
  - O_WAITn is combinationally low whenever cpu_req=1 in IDLE or CPU_ACC.
  - It is high in HOLD.
- cpu_allowed:
  - Without the optional feature: ~I_CMPBLK.
  - With it: 1, gated by win/guard.
- Boundary cases:
  - If win rises while in CPU_ACC (I_CMPBLK asserted mid-access), the CPU access completes. The fetch then starts the next clock, and O_FETCH_LATE pulses with O_TILE_VLD.
  - A request arriving on the same clock as win rising: the fetch wins and the CPU waits.
  - Strobes changing during CPU_ACC: the access type is sampled on entry.

Optional Feature:
- Macro MARIO_VRAM_CPU_ACTIVE_EN.
- Defined: CPU accesses are also granted during active display, in non-window, non-guard phases.
- Undefined: matches the original board. CPU accesses are granted only while I_CMPBLK=0, and the CPU is held in wait otherwise.

Decomposition:
- Package mario_vram_arb_pkg: state enum (IDLE, CPU_ACC, HOLD), WIN_PHASE=2'b11, GUARD_PHASE=3'b101, and parameter range limits.
- One sub-module: mario_vram_slot_gen, which decodes win/guard, detects the rising edge of win and generates O_VRAMBUSYn.

Test Plan:
- I_CMPBLK=0, write 8'hA5 to 10'h123 -> O_WAITn low 3 clocks, WE high 3 clocks at AB=10'h123, HOLD until I_CPU_WRn=1, no second write.
- I_CMPBLK=0, read 10'h123 holding 8'h3C -> O_CPU_DB=8'h3C from the last CPU_ACC clock until I_CPU_RDn=1, then 8'h00.
- I_CMPBLK=1, I_VID_AB=10'h2F0, RAM=8'h47 -> at H_CNT[3:0]=4'hC, O_RAM_AB=10'h2F0; 2 clocks later O_TILE=8'h47 and O_TILE_VLD pulses once.
- I_CMPBLK=1, request during H_CNT[3:1]=3'b101: with the macro, waits until H_CNT[3:0]=4'h0 and is then granted; without it, waits until I_CMPBLK=0.
- I_CMPBLK rises during CPU_ACC -> the write completes, the fetch follows on the next clock, and O_FETCH_LATE pulses.
- I_RST pulse mid-CPU_ACC -> all outputs return to reset values asynchronously, no RAM write.
